// File: rtl/xm23_pipe_pkg.sv
// Shared types and constants for the XM23 pipeline stages.
package xm23_pipe_pkg;

  localparam int          WORD_W           = 16;
  localparam logic [15:0] PC_INC           = 16'd2;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating event counters for the fetch stage; compiled only when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_evt,
  input  logic        stall_evt,
  input  logic        redirect_evt,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_redirects
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetches      <= '0;
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (fetch_evt && (perf_fetches != '1))
        perf_fetches <= perf_fetches + 32'd1;
      if (stall_evt && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect_evt && (perf_redirects != '1))
        perf_redirects <= perf_redirects + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/fetch_stage.sv
// XM23 stage-1 instruction fetch: owns the fetch PC, runs the imem req/ack handshake, feeds ir to decode.
// Optional counters under FETCH_PERF_CNT_EN; the perf ports always exist and read 0 when disabled.
module fetch_stage
  import xm23_pipe_pkg::*;
#(
  parameter int              PC_W     = WORD_W,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_next,
  input  logic [7:0]      stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] ir,
  output logic            ir_valid,
  output logic [PC_W-1:0] pc_out,
  output logic [31:0]     perf_fetches,
  output logic [31:0]     perf_stall_cycles,
  output logic [15:0]     perf_redirects
);

  // state | meaning
  // IDLE  | first cycle after reset, no request yet
  // REQ   | request live at fetch_pc, ir empty
  // HOLD  | ir valid, waiting for decode to consume it
  // DRAIN | stale request still outstanding after a redirect; its data is dropped

  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:1], 1'b0};

  fetch_state_t    state;
  logic [PC_W-1:0] fetch_pc;
  logic            hold;
  logic            unused_lsb;

  assign hold       = |stall;
  // fetch_pc is kept word-aligned, so the incoming byte bits are never needed
  assign unused_lsb = redirect_pc[0] ^ pc_next[0];

  function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:1], 1'b0};
  endfunction

  // imem_addr is registered separately so it stays on the old address in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC_ALIGNED;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC_ALIGNED;
      ir        <= '0;
      ir_valid  <= 1'b0;
      pc_out    <= RESET_PC_ALIGNED;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc  <= align(redirect_pc);
            imem_addr <= align(redirect_pc);
          end else begin
            imem_addr <= fetch_pc;
          end
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= align(redirect_pc);
            if (imem_ack) imem_addr <= align(redirect_pc);
            else          state     <= DRAIN;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            pc_out   <= fetch_pc;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            ir_valid  <= 1'b0;
            fetch_pc  <= align(redirect_pc);
            imem_addr <= align(redirect_pc);
            imem_req  <= 1'b1;
            state     <= REQ;
          end else if (!hold) begin
            ir_valid  <= 1'b0;
            fetch_pc  <= align(pc_next);
            imem_addr <= align(pc_next);
            imem_req  <= 1'b1;
            state     <= REQ;
          end
        end
        DRAIN: begin
          if (redirect_valid) fetch_pc <= align(redirect_pc);
          if (imem_ack) begin
            imem_addr <= redirect_valid ? align(redirect_pc) : fetch_pc;
            state     <= REQ;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_evt;
  logic stall_evt;

  assign fetch_evt = (state == REQ) && imem_ack && !redirect_valid;
  assign stall_evt = (state == HOLD) && hold;

  fetch_perf_counters u_perf (
    .clk               (clk),
    .rst               (rst),
    .fetch_evt         (fetch_evt),
    .stall_evt         (stall_evt),
    .redirect_evt      (redirect_valid),
    .perf_fetches      (perf_fetches),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
  );
`else
  assign perf_fetches      = '0;
  assign perf_stall_cycles = '0;
  assign perf_redirects    = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage (stage 1) of the XM23 pipeline.
- Owns the fetch PC and runs a req/ack handshake to instruction memory. Latches the returned word into the IR presented to decode (stage 2).
- Takes the predicted next PC (PC_next) and the stall vector from pipeline_controller, plus a redirect from exec when a predicted branch is wrong.
- Drives pc_out, the PC of the instruction held in the IR, back to the controller's PC_in.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset (bit 0 ignored).
- PC_W, 16, PC and instruction word width.

Ports:
- clk  in  1  pipeline clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- pc_next  in  16  predicted next PC from pipeline_controller.
- stall  in  8  per-register stall vector from pipeline_controller; any bit set means hold.
- redirect_valid  in  1  exec misprediction; refetch from redirect_pc.
- redirect_pc  in  16  corrected PC (LBPC or LBPC_LR selected by exec).
- imem_req  out  1  instruction memory read request.
- imem_addr  out  16  word-aligned read address.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  16  instruction word.
- ir  out  16  instruction register to decode.
- ir_valid  out  1  ir holds a live instruction.
- pc_out  out  16  address of the instruction in ir.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on posedge clk.
- Reset values: state=IDLE, fetch_pc=RESET_PC & ~1, imem_req=0, ir=0, ir_valid=0, pc_out=RESET_PC & ~1.
- Reset asserted mid-handshake abandons the outstanding request; memory must tolerate a dropped req.
- imem_addr = fetch_pc with bit 0 forced to 0.
- imem_req is a registered decode of state: 1 in REQ and DRAIN, else 0.
- Handshake rule: once imem_req rises, imem_req and imem_addr stay stable until the cycle imem_ack=1. Zero-wait ack (ack in the first req cycle) is legal. Only one request is outstanding at a time.
- hold = |stall.
- FSM transitions, evaluated on each posedge; redirect_valid has top priority in every state:
  - IDLE: goes to REQ unconditionally (one cycle after reset release).
  - REQ, redirect_valid, no ack: fetch_pc<=redirect_pc, go to DRAIN.
  - REQ, redirect_valid with ack: discard rdata, fetch_pc<=redirect_pc, stay in REQ.
  - REQ, ack only: ir<=imem_rdata, pc_out<=fetch_pc, ir_valid<=1, go to HOLD.
  - HOLD, redirect_valid: ir_valid<=0, fetch_pc<=redirect_pc, go to REQ.
  - HOLD, !hold: the instruction is consumed by decode. ir_valid<=0, fetch_pc<=pc_next, go to REQ.
  - HOLD, hold: ir, pc_out and ir_valid are unchanged.
  - DRAIN: req stays high with the old address. On ack, discard rdata and go to REQ at the new fetch_pc. A repeated redirect in DRAIN overwrites fetch_pc (latest wins).
- pc_next timing: the controller updates pc_next on negedge, so pc_next is stable by the posedge following a pc_out load. HOLD therefore lasts at least one cycle and pc_next is always sampled valid.
- Throughput: one instruction per 2 cycles with zero-wait memory. Latency from consume to new ir_valid is 2 cycles.
- Wrap-around: fetch_pc arithmetic is modulo 2^16; pc_next=16'hFFFE followed by +2 yields 16'h0000, with no flag.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_fetches (32): counts each accepted ack.
  - perf_stall_cycles (32): counts cycles in HOLD with hold=1.
  - perf_redirects (16): counts redirect_valid cycles.
- All counters saturate at max and reset to 0 on rst.
- When undefined, the same ports exist and are tied to 0 so the debug/visualization interface is unchanged.

Decomposition:
- Package xm23_pipe_pkg holds:
  - fetch_state_t enum {IDLE, REQ, HOLD, DRAIN};
  - WORD_W=16, PC_INC=16'd2;
  - default RESET_PC constant.
- One sub-module, fetch_perf_counters, instantiated only under FETCH_PERF_CNT_EN.

Test Plan:
1. rst high 2 cycles, then low; memory acks immediately -> imem_req=1 with addr 0000 in cycle 2; ir=rdata, ir_valid=1, pc_out=0000 next cycle.
2. ir_valid, stall=8'h04 for 3 cycles, then 0 with pc_next=0002 -> ir and pc_out held 3 cycles; next request addr=0002.
3. In REQ, ack delayed 3 cycles; redirect_valid with redirect_pc=0040 in wait cycle 1 -> req/addr held at old value until ack; that data is dropped (ir_valid stays 0); next req addr=0040.
4. Redirect and ack in the same cycle, redirect_pc=0100 -> rdata discarded; next req addr=0100, ir_valid=0.
5. HOLD with stall=0 and pc_next=FFFE, then pc_next=FFFE+2 -> fetch at FFFE, next at 0000, no error.
6. FETCH_PERF_CNT_EN defined; run 10 fetches, 4 stall cycles, 2 redirects -> perf_fetches=10, perf_stall_cycles=4, perf_redirects=2. Without the macro, all three read 0.
